phase1_datapath: RTL and testbench
==================================

Name: phase1_datapath

Overview:
- Single-bus 32-bit CPU datapath slice for phase-1 bring-up.
- Contains R1–R3, PC, MAR, MDR, IR, Y, a 64-bit Z, a bus multiplexer and an ALU.
- An external control sequence drives all register enables, bus-drive selects, memory read and the ALU opcode.
- Internal state is exposed for verification.

Parameters:
- WIDTH, 32, datapath word width. Z is 2*WIDTH bits wide.

Ports:
- Clock  in  1  system clock; all registers update on the rising edge.
- Clear  in  1  reset, asynchronous and active-low; clears every register.
- R1in, R2in, R3in  in  1 each  load the bus into R1 / R2 / R3.
- MARin, PCin, IRin, Yin  in  1 each  load the bus into MAR / PC / IR / Y.
- MDRin  in  1  load MDR_data_in into MDR.
- Zin  in  1  load the ALU result into Z.
- IncrementPC  in  1  when qualified by PCin, PC loads PC+1 instead of the bus.
- PCout, ZLOout, MDRout, R2out, R3out  in  1 each  bus-drive selects.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- ALUControl  in  5  ALU operation code.
- Mdatain  in  WIDTH  memory read data.
- R1_data_out, R2_data_out, R3_data_out  out  WIDTH  register contents.
- big_boy_bus  out  WIDTH  current bus value.
- MDR_data_in  out  WIDTH  MDR input mux output.
- MDR_data_out  out  WIDTH  MDR contents.
- Y_data_out  out  WIDTH  Y contents.
- Z_data_out  out  2*WIDTH  Z contents, {HI,LO}.

Behaviour:
- Reset: Clear=0 asynchronously forces R1–R3, PC, MAR, MDR, IR, Y and Z to 0, so every register output reads 0. Clear dominates any simultaneous enable.
- Registers: on a rising edge with the enable high, the register captures its source. With the enable low, it holds.
- Bus: combinational.
  - Priority when several selects are high: MDRout > ZLOout > PCout > R2out > R3out.
  - ZLOout drives Z[31:0].
  - With no select high, the bus is 0.
- MDR_data_in = Read ? Mdatain : bus (combinational).
- PC: PCin&IncrementPC gives PC+1, wrapping modulo 2^WIDTH. PCin alone gives the bus value.
- ALU: combinational, with A = Y and B = bus. The result is 64-bit and is latched into Z by Zin.
  - Shift and rotate amounts use B[4:0].
  - All 32-bit results are placed in Z_LO with Z_HI = 0.

ALU opcodes:
- 00000: pass B.
- 00011: ADD, A+B, wraps.
- 00100: SUB, A-B.
- 00101: SHR, A logical >> B.
- 00110: SHRA, A arithmetic >> B.
- 00111: SHL, A << B.
- 01000: ROR, A rotated right by B.
- 01001: ROL, A rotated left by B.
- 01011: AND, A&B.
- 01100: OR, A|B.
- 01101: NEG, -B.
- 01110: NOT, ~B.
- 01111: MUL, signed A*B. Full 64-bit product, HI = upper word, LO = lower word.
- 10000: DIV, signed A/B. LO = quotient (truncates toward zero), HI = remainder (sign of A). B = 0 gives Z = 0.
- Any other code gives Z = 0.

Timing:
- A bus source loaded on one edge is visible on the bus in the same cycle that its select is high. The destination captures it at the next rising edge.
- There is no pipelining and no handshake. Each register transfer takes one cycle.

Test Plan:
- Register preload: Mdatain=0x12, Read=1, MDRin=1 for one edge, so MDR=0x12. Then MDRout=1, R2in=1, so R2=0x12. Repeat with 0x14 into R3 and 0x18 into R1.
- OR sequence with R2=0x12 and R3=0x14:
  - Fetch: PCout/MARin/Zin, then ZLOout/PCin/IncrementPC/Read/MDRin with Mdatain=0x28918000, then MDRout/IRin. Required: PC=1, IR=0x28918000.
  - Execute: R2out/Yin gives Y=0x12. R3out with ALUControl=01100 and Zin gives Z=0x0000_0000_0000_0016. ZLOout/R1in gives R1=0x16.
- ADD/SUB: Y=0xFFFFFFFF, bus=1 with ALU 00011 gives Z_LO=0. Y=5, bus=7 with 00100 gives Z_LO=0xFFFFFFFE.
- MUL/DIV:
  - Y=-3, bus=7 with 01111 gives Z=0xFFFFFFFF_FFFFFFEB.
  - Y=-7, bus=2 with 10000 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Divide by 0 gives Z=0.
- Bus priority/idle: MDRout and R2out high together put MDR on the bus. No select high gives bus=0. Read=0 with MDRin copies the bus into MDR.
- Reset: load nonzero values into all registers, then pulse Clear=0 mid-cycle with no clock edge. All outputs are 0 immediately. An enable asserted during reset has no effect.

Source files
------------

// File: rtl/phase1_datapath.sv
// Phase-1 single-bus CPU datapath slice: general registers, PC/MAR/MDR/IR, Y/Z and ALU
// steered by an external control sequence, with internal state exposed on ports.
module phase1_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               R1in,
  input  logic               R2in,
  input  logic               R3in,
  input  logic               MARin,
  input  logic               PCin,
  input  logic               IRin,
  input  logic               Yin,
  input  logic               MDRin,
  input  logic               Zin,
  input  logic               IncrementPC,
  input  logic               PCout,
  input  logic               ZLOout,
  input  logic               MDRout,
  input  logic               R2out,
  input  logic               R3out,
  input  logic               Read,
  input  logic [4:0]         ALUControl,
  input  logic [WIDTH-1:0]   Mdatain,
  output logic [WIDTH-1:0]   R1_data_out,
  output logic [WIDTH-1:0]   R2_data_out,
  output logic [WIDTH-1:0]   R3_data_out,
  output logic [WIDTH-1:0]   big_boy_bus,
  output logic [WIDTH-1:0]   MDR_data_in,
  output logic [WIDTH-1:0]   MDR_data_out,
  output logic [WIDTH-1:0]   Y_data_out,
  output logic [2*WIDTH-1:0] Z_data_out
);

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01011;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_NEG  = 5'b01101;
  localparam logic [4:0] OP_NOT  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  logic [WIDTH-1:0]   pc_reg, mar_reg, mdr_reg, ir_reg, y_reg;
  logic [2*WIDTH-1:0] z_reg;
  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_result;
  logic [WIDTH-1:0]   gpr_q [3];
  logic [2:0]         gpr_en;

  assign gpr_en = {R3in, R2in, R1in};

  // R1..R3 are identical bus-loaded registers.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_gpr
      logic [WIDTH-1:0] data_reg;
      always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)          data_reg <= '0;
        else if (gpr_en[gi]) data_reg <= bus;
      end
      assign gpr_q[gi] = data_reg;
    end
  endgenerate

  // Bus priority: MDR > Z low word > PC > R2 > R3, idle bus reads 0.
  always_comb begin
    bus = '0;
    if (MDRout)      bus = mdr_reg;
    else if (ZLOout) bus = z_reg[WIDTH-1:0];
    else if (PCout)  bus = pc_reg;
    else if (R2out)  bus = gpr_q[1];
    else if (R3out)  bus = gpr_q[2];
  end

  assign MDR_data_in = Read ? Mdatain : bus;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc_reg  <= '0;
      mar_reg <= '0;
      mdr_reg <= '0;
      ir_reg  <= '0;
      y_reg   <= '0;
      z_reg   <= '0;
    end else begin
      if (PCin)  pc_reg  <= IncrementPC ? pc_reg + {{(WIDTH-1){1'b0}}, 1'b1} : bus;
      if (MARin) mar_reg <= bus;
      if (MDRin) mdr_reg <= MDR_data_in;
      if (IRin)  ir_reg  <= bus;
      if (Yin)   y_reg   <= bus;
      if (Zin)   z_reg   <= alu_result;
    end
  end

  // ALU: A = Y, B = bus; single-word results land in the low half of Z.
  logic [4:0]           shamt;
  logic [2*WIDTH-1:0]   rot_r, rot_l;
  logic [2*WIDTH-1:0]   mul_a, mul_b, mul_p;
  logic [WIDTH-1:0]     quot, rem, lo;

  always_comb begin
    shamt = bus[4:0];
    rot_r = {y_reg, y_reg} >> shamt;
    rot_l = {y_reg, y_reg} << shamt;
    mul_a = {{WIDTH{y_reg[WIDTH-1]}}, y_reg};
    mul_b = {{WIDTH{bus[WIDTH-1]}}, bus};
    mul_p = mul_a * mul_b;
    quot  = '0;
    rem   = '0;
    if (bus != '0) begin
      quot = $signed(y_reg) / $signed(bus);
      rem  = $signed(y_reg) % $signed(bus);
    end
    lo         = '0;
    alu_result = '0;
    case (ALUControl)
      OP_PASS: lo = bus;
      OP_ADD:  lo = y_reg + bus;
      OP_SUB:  lo = y_reg - bus;
      OP_SHR:  lo = y_reg >> shamt;
      OP_SHRA: lo = $signed(y_reg) >>> shamt;
      OP_SHL:  lo = y_reg << shamt;
      OP_ROR:  lo = rot_r[WIDTH-1:0];
      OP_ROL:  lo = rot_l[2*WIDTH-1:WIDTH];
      OP_AND:  lo = y_reg & bus;
      OP_OR:   lo = y_reg | bus;
      OP_NEG:  lo = '0 - bus;
      OP_NOT:  lo = ~bus;
      default: lo = '0;
    endcase
    if (ALUControl == OP_MUL)      alu_result = mul_p;
    else if (ALUControl == OP_DIV) alu_result = {rem, quot};
    else                           alu_result = {{WIDTH{1'b0}}, lo};
  end

  assign R1_data_out  = gpr_q[0];
  assign R2_data_out  = gpr_q[1];
  assign R3_data_out  = gpr_q[2];
  assign big_boy_bus  = bus;
  assign MDR_data_out = mdr_reg;
  assign Y_data_out   = y_reg;
  assign Z_data_out   = z_reg;

endmodule

// File: tb/tb_phase1_datapath.sv
// Directed bench for phase1_datapath: register transfers, fetch/execute, ALU ops,
// bus priority and asynchronous clear, all against hand-computed values.
module tb_phase1_datapath;
  localparam int W = 32;

  logic Clock = 1'b0;
  logic Clear;
  logic R1in, R2in, R3in, MARin, PCin, IRin, Yin, MDRin, Zin, IncrementPC;
  logic PCout, ZLOout, MDRout, R2out, R3out, Read;
  logic [4:0]     ALUControl;
  logic [W-1:0]   Mdatain;
  logic [W-1:0]   R1_data_out, R2_data_out, R3_data_out, big_boy_bus;
  logic [W-1:0]   MDR_data_in, MDR_data_out, Y_data_out;
  logic [2*W-1:0] Z_data_out;

  int checks = 0;
  int errors = 0;

  phase1_datapath #(.WIDTH(W)) dut (
    .Clock(Clock), .Clear(Clear),
    .R1in(R1in), .R2in(R2in), .R3in(R3in), .MARin(MARin), .PCin(PCin), .IRin(IRin),
    .Yin(Yin), .MDRin(MDRin), .Zin(Zin), .IncrementPC(IncrementPC),
    .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
    .Read(Read), .ALUControl(ALUControl), .Mdatain(Mdatain),
    .R1_data_out(R1_data_out), .R2_data_out(R2_data_out), .R3_data_out(R3_data_out),
    .big_boy_bus(big_boy_bus), .MDR_data_in(MDR_data_in), .MDR_data_out(MDR_data_out),
    .Y_data_out(Y_data_out), .Z_data_out(Z_data_out)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {R1in, R2in, R3in, MARin, PCin, IRin, Yin, MDRin, Zin, IncrementPC} = '0;
    {PCout, ZLOout, MDRout, R2out, R3out, Read} = '0;
    ALUControl = 5'b00000;
    Mdatain    = '0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [W-1:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  task automatic load_y(input logic [W-1:0] v);
    load_mdr(v);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    load_y(a);
    load_mdr(b);
    MDRout = 1'b1; ALUControl = op; Zin = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    Clear = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_r1", {32'h0, R1_data_out}, 64'h0);
    check("reset_mdr", {32'h0, MDR_data_out}, 64'h0);
    check("reset_z", Z_data_out, 64'h0);
    check("reset_bus", {32'h0, big_boy_bus}, 64'h0);
    Clear = 1'b1;
    tick();

    // Register preload
    Mdatain = 32'h12; Read = 1'b1; MDRin = 1'b1;
    #1 check("mdr_in_read", {32'h0, MDR_data_in}, 64'h12);
    tick();
    check("mdr_load", {32'h0, MDR_data_out}, 64'h12);
    MDRout = 1'b1; R2in = 1'b1;
    #1 check("bus_mdr", {32'h0, big_boy_bus}, 64'h12);
    tick();
    check("r2_load", {32'h0, R2_data_out}, 64'h12);
    load_mdr(32'h14); MDRout = 1'b1; R3in = 1'b1; tick();
    check("r3_load", {32'h0, R3_data_out}, 64'h14);
    load_mdr(32'h18); MDRout = 1'b1; R1in = 1'b1; tick();
    check("r1_load", {32'h0, R1_data_out}, 64'h18);

    // Fetch
    PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; tick();
    check("fetch_z_pc", Z_data_out, 64'h0);
    ZLOout = 1'b1; PCin = 1'b1; IncrementPC = 1'b1; Read = 1'b1; MDRin = 1'b1;
    Mdatain = 32'h2891_8000; tick();
    check("fetch_mdr", {32'h0, MDR_data_out}, 64'h2891_8000);
    MDRout = 1'b1; IRin = 1'b1; tick();
    check("fetch_ir", {32'h0, dut.ir_reg}, 64'h2891_8000);
    PCout = 1'b1;
    #1 check("fetch_pc", {32'h0, big_boy_bus}, 64'h1);
    tick();

    // Execute OR
    R2out = 1'b1; Yin = 1'b1; tick();
    check("or_y", {32'h0, Y_data_out}, 64'h12);
    R3out = 1'b1; ALUControl = 5'b01100; Zin = 1'b1; tick();
    check("or_z", Z_data_out, 64'h16);
    ZLOout = 1'b1; R1in = 1'b1; tick();
    check("or_r1", {32'h0, R1_data_out}, 64'h16);

    // ALU vectors
    alu_op(5'b00011, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap", Z_data_out, 64'h0);
    alu_op(5'b00100, 32'h5, 32'h7);
    check("sub_neg", Z_data_out, 64'h0000_0000_FFFF_FFFE);
    alu_op(5'b01111, 32'hFFFF_FFFD, 32'h7);
    check("mul_signed", Z_data_out, 64'hFFFF_FFFF_FFFF_FFEB);
    alu_op(5'b10000, 32'hFFFF_FFF9, 32'h2);
    check("div_signed", Z_data_out, 64'hFFFF_FFFF_FFFF_FFFD);
    alu_op(5'b10000, 32'hFFFF_FFF9, 32'h0);
    check("div_zero", Z_data_out, 64'h0);
    alu_op(5'b00110, 32'h8000_0000, 32'h4);
    check("shra", Z_data_out, 64'h0000_0000_F800_0000);
    alu_op(5'b00101, 32'h8000_0000, 32'h4);
    check("shr", Z_data_out, 64'h0000_0000_0800_0000);
    alu_op(5'b00111, 32'h0000_0003, 32'h1F);
    check("shl", Z_data_out, 64'h0000_0000_8000_0000);
    alu_op(5'b01001, 32'h8000_0001, 32'h1);
    check("rol", Z_data_out, 64'h0000_0000_0000_0003);
    alu_op(5'b01000, 32'h0000_0001, 32'h4);
    check("ror", Z_data_out, 64'h0000_0000_1000_0000);
    alu_op(5'b01011, 32'hF0F0_FFFF, 32'h0FF0_1234);
    check("and", Z_data_out, 64'h0000_0000_00F0_1234);
    alu_op(5'b01101, 32'h0, 32'h5);
    check("neg", Z_data_out, 64'h0000_0000_FFFF_FFFB);
    alu_op(5'b01110, 32'h0, 32'h0000_FFFF);
    check("not", Z_data_out, 64'h0000_0000_FFFF_0000);
    alu_op(5'b00001, 32'h5, 32'h5);
    check("bad_op", Z_data_out, 64'h0);

    // Bus priority and idle
    load_mdr(32'hAAAA);
    MDRout = 1'b1; R2out = 1'b1;
    #1 check("prio_mdr_r2", {32'h0, big_boy_bus}, 64'hAAAA);
    idle(); R2out = 1'b1; R3out = 1'b1;
    #1 check("prio_r2_r3", {32'h0, big_boy_bus}, 64'h12);
    idle();
    #1 check("bus_idle", {32'h0, big_boy_bus}, 64'h0);
    R2out = 1'b1; MDRin = 1'b1; Read = 1'b0; tick();
    check("mdr_from_bus", {32'h0, MDR_data_out}, 64'h12);
    MDRout = 1'b1; ALUControl = 5'b00000; Zin = 1'b1; Yin = 1'b1; tick();
    check("pass_z", Z_data_out, 64'h12);
    ZLOout = 1'b1; PCout = 1'b1;
    #1 check("prio_z_pc", {32'h0, big_boy_bus}, 64'h12);
    idle();

    // Asynchronous clear mid-cycle with an enable held
    #2;
    Clear = 1'b0; MDRout = 1'b1; R1in = 1'b1;
    #1;
    check("clr_r1", {32'h0, R1_data_out}, 64'h0);
    check("clr_r2", {32'h0, R2_data_out}, 64'h0);
    check("clr_r3", {32'h0, R3_data_out}, 64'h0);
    check("clr_mdr", {32'h0, MDR_data_out}, 64'h0);
    check("clr_y", {32'h0, Y_data_out}, 64'h0);
    check("clr_z", Z_data_out, 64'h0);
    check("clr_pc", {32'h0, dut.pc_reg}, 64'h0);
    @(posedge Clock);
    #1;
    check("clr_hold_r1", {32'h0, R1_data_out}, 64'h0);
    Clear = 1'b1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
